axi_rd_responder: RTL

- AXI4 read-channel responder (AR in, R out) that models the DDR side of the prefetcher's master read port. It answers the read requests issued by the prefetcher controller.
- Requests are queued in order. After a programmable latency, each request is answered with len+1 R beats carrying the request's ID and address-derived data.
- Used as the memory model in prefetcher benches and as a reusable stub slave in integration.

---
 rtl/axi_rd_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder: queues AR requests in order and answers each
// after a programmable latency with len+1 R beats of address-derived data.
module axi_rd_responder #(
   parameter int ADDR_BITS       = 64,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int TID_WIDTH       = 8,
   parameter int DATA_WIDTH      = 64,
   parameter int LOG_QUEUE_SIZE  = 2,
   parameter int LAT_WIDTH       = 8
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       en,
   input  logic                       flush,
   input  logic [LAT_WIDTH-1:0]       latency,
   input  logic                       ar_valid,
   output logic                       ar_ready,
   input  logic [ADDR_BITS-1:0]       ar_addr,
   input  logic [BURST_LEN_WIDTH-1:0] ar_len,
   input  logic [TID_WIDTH-1:0]       ar_id,
   output logic                       r_valid,
   input  logic                       r_ready,
   output logic [TID_WIDTH-1:0]       r_id,
   output logic [DATA_WIDTH-1:0]      r_data,
   output logic                       r_last,
   output logic [LOG_QUEUE_SIZE:0]    reqCnt
);

   localparam int DEPTH = 1 << LOG_QUEUE_SIZE;
   localparam logic [ADDR_BITS-1:0] STRIDE = ADDR_BITS'(DATA_WIDTH / 8);

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   // Address to data-bus mapping: zero-extend or truncate the byte address.
   function automatic logic [DATA_WIDTH-1:0] fit_data(input logic [ADDR_BITS-1:0] a);
      return DATA_WIDTH'(a);
   endfunction

   logic [ADDR_BITS-1:0]       q_addr [DEPTH];
   logic [BURST_LEN_WIDTH-1:0] q_len  [DEPTH];
   logic [TID_WIDTH-1:0]       q_id   [DEPTH];
   logic [LOG_QUEUE_SIZE-1:0]  wr_ptr;
   logic [LOG_QUEUE_SIZE-1:0]  rd_ptr;

   logic [ADDR_BITS-1:0]       head_addr;
   logic [BURST_LEN_WIDTH-1:0] head_len;
   logic [TID_WIDTH-1:0]       head_id;

   state_t                     state;
   logic [LAT_WIDTH-1:0]       wcnt;
   logic [BURST_LEN_WIDTH:0]   beat;
   logic [BURST_LEN_WIDTH:0]   beat_nxt;
   logic [ADDR_BITS-1:0]       cur_addr;
   logic [ADDR_BITS-1:0]       addr_nxt;

   logic push;
   logic pop;

   // The MSB of reqCnt is set only when the queue holds DEPTH entries.
   assign ar_ready = resetN && en && !flush && !reqCnt[LOG_QUEUE_SIZE];
   assign push     = ar_valid && ar_ready;
   assign pop      = r_valid && r_ready && r_last;

   assign head_addr = q_addr[rd_ptr];
   assign head_len  = q_len[rd_ptr];
   assign head_id   = q_id[rd_ptr];

   assign beat_nxt = beat + (BURST_LEN_WIDTH + 1)'(1);
   assign addr_nxt = cur_addr + STRIDE;

   // Request storage: payload only, no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= ar_addr;
         q_len[wr_ptr]  <= ar_len;
         q_id[wr_ptr]   <= ar_id;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         reqCnt <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         reqCnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + LOG_QUEUE_SIZE'(1);
         if (pop)
            rd_ptr <= rd_ptr + LOG_QUEUE_SIZE'(1);
         case ({push, pop})
            2'b10:   reqCnt <= reqCnt + (LOG_QUEUE_SIZE + 1)'(1);
            2'b01:   reqCnt <= reqCnt - (LOG_QUEUE_SIZE + 1)'(1);
            default: reqCnt <= reqCnt;
         endcase
      end
   end

   // Response FSM; R outputs are registered so the payload is stable under backpressure.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state    <= IDLE;
         wcnt     <= '0;
         beat     <= '0;
         cur_addr <= '0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_id     <= '0;
         r_data   <= '0;
      end else if (flush) begin
         state   <= IDLE;
         wcnt    <= '0;
         beat    <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en && (reqCnt != '0)) begin
                  state <= WAIT;
                  wcnt  <= latency;
               end
            end
            WAIT: begin
               if (wcnt == '0) begin
                  state    <= BURST;
                  beat     <= '0;
                  cur_addr <= head_addr;
                  r_valid  <= 1'b1;
                  r_id     <= head_id;
                  r_data   <= fit_data(head_addr);
                  r_last   <= (head_len == '0);
               end else begin
                  wcnt <= wcnt - LAT_WIDTH'(1);
               end
            end
            BURST: begin
               if (r_ready) begin
                  if (r_last) begin
                     state   <= IDLE;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                  end else begin
                     beat     <= beat_nxt;
                     cur_addr <= addr_nxt;
                     r_data   <= fit_data(addr_nxt);
                     r_last   <= (beat_nxt == {1'b0, head_len});
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
